// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int MAX_N = 32;

    // Index to one-hot; callers narrow the result to their requester count.
    function automatic logic [MAX_N-1:0] to_onehot(input int unsigned idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr, wrapping.
module rr_prio_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j_s;

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j_s   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j_s = IW'((int'(ptr) + k) % N);
            if (req[j_s]) begin
                found = 1'b1;
                idx   = j_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// N-way weighted round-robin arbiter with registered one-hot grant and burst credit.
// Optional macro WRR_LOCK_EN adds a lock input that holds the grant past its credit.
module weighted_rr_arbiter
    import wrr_arb_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int WW = 4,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
`ifdef WRR_LOCK_EN
    input  logic            lock,
`endif
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   grant_ID,
    output logic            grant_valid,
    output logic [WW-1:0]   credit_left
);

    state_e        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] credit_q, credit_d;
    logic          valid_q, valid_d;

    logic          found_s;
    logic [IW-1:0] pick_idx_s;
    logic [WW-1:0] w_sel_s;
    logic          keep_s;
    logic          lock_keep_s;

    rr_prio_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (found_s),
        .idx   (pick_idx_s)
    );

    // Weight of the candidate winner, selected with constant indices only.
    always_comb begin
        w_sel_s = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx_s == IW'(i)) begin
                w_sel_s = weight[i*WW +: WW];
            end else begin
                w_sel_s = w_sel_s;
            end
        end
    end

    assign keep_s = (state_q == HOLD) && req[id_q] && (credit_q > WW'(1));
`ifdef WRR_LOCK_EN
    assign lock_keep_s = (state_q == HOLD) && req[id_q] && lock;
`else
    assign lock_keep_s = 1'b0;
`endif

    // Next-state: disable, continue burst, locked hold, new winner, or go idle.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        valid_d  = valid_q;
        if (!en) begin
            state_d  = IDLE;
            grant_d  = '0;
            id_d     = '0;
            credit_d = '0;
            valid_d  = 1'b0;
        end else if (keep_s) begin
            credit_d = credit_q - WW'(1);
        end else if (lock_keep_s) begin
            credit_d = credit_q;
        end else if (found_s) begin
            state_d  = HOLD;
            grant_d  = N'(to_onehot(int'(pick_idx_s)));
            id_d     = pick_idx_s;
            credit_d = (w_sel_s == '0) ? WW'(1) : w_sel_s;
            ptr_d    = (pick_idx_s == IW'(N - 1)) ? '0 : pick_idx_s + IW'(1);
            valid_d  = 1'b1;
        end else begin
            state_d  = IDLE;
            grant_d  = '0;
            id_d     = '0;
            credit_d = '0;
            valid_d  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            id_q     <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            valid_q  <= valid_d;
        end
    end

    assign grant       = grant_q;
    assign grant_ID    = id_q;
    assign grant_valid = valid_q;
    assign credit_left = credit_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Self-checking bench for weighted_rr_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_weighted_rr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  req;
    logic [N*WW-1:0] weight;
`ifdef WRR_LOCK_EN
    logic          lock;
`endif
    logic [N-1:0]  grant;
    logic [1:0]    grant_ID;
    logic          grant_valid;
    logic [WW-1:0] credit_left;

    int total;
    int passed;
    int failed;

    // Reference model: who holds the bus, how many cycles remain, where priority starts.
    bit m_valid;
    int m_id;
    int m_credit;
    int m_ptr;

    weighted_rr_arbiter #(.N(N), .WW(WW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .weight      (weight),
`ifdef WRR_LOCK_EN
        .lock        (lock),
`endif
        .grant       (grant),
        .grant_ID    (grant_ID),
        .grant_valid (grant_valid),
        .credit_left (credit_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int wt(input int i);
        int v;
        v = int'(weight[i*WW +: WW]);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_id     = 0;
        m_credit = 0;
        m_ptr    = 0;
    endtask

    task automatic model_step();
        bit lk;
        int w;
`ifdef WRR_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        if (!en) begin
            m_valid  = 1'b0;
            m_id     = 0;
            m_credit = 0;
        end else if (m_valid && req[m_id] && (m_credit > 1 || lk)) begin
            m_credit = (m_credit > 1) ? m_credit - 1 : 1;
        end else begin
            w = -1;
            for (int off = 0; off < N; off++) begin
                if (w < 0 && req[(m_ptr + off) % N]) w = (m_ptr + off) % N;
            end
            if (w >= 0) begin
                m_valid  = 1'b1;
                m_id     = w;
                m_credit = wt(w);
                m_ptr    = (w + 1) % N;
            end else begin
                m_valid  = 1'b0;
                m_id     = 0;
                m_credit = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".grant"},  32'(grant), m_valid ? (32'd1 << m_id) : 32'd0);
        chk({tag, ".id"},     32'(grant_ID), 32'(m_id));
        chk({tag, ".valid"},  32'(grant_valid), 32'(m_valid));
        chk({tag, ".credit"}, 32'(credit_left), 32'(m_credit));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic setw(input int i, input int v);
        weight[i*WW +: WW] = WW'(v);
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst.grant", 32'(grant), 32'd0);
        chk("rst.id", 32'(grant_ID), 32'd0);
        chk("rst.valid", 32'(grant_valid), 32'd0);
        chk("rst.credit", 32'(credit_left), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        rst    = 1'b1;
        en     = 1'b0;
        req    = '0;
        weight = '0;
`ifdef WRR_LOCK_EN
        lock   = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        hard_reset();

        // 1: equal weights rotate; async reset mid-run clears outputs at once
        en = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < N; i++) setw(i, 1);
        for (int i = 0; i < 6; i++) begin
            cycle("t1");
            chk("t1.seq", 32'(grant_ID), 32'(i % 4));
        end
        hard_reset();
        cycle("t1.after_rst");
        chk("t1.first_after_rst", 32'(grant_ID), 32'd0);

        // 2: weight 3 on requester 0
        hard_reset();
        setw(0, 3);
        for (int i = 0; i < 9; i++) begin
            int exp_id [9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
            int exp_cr [9] = '{3, 2, 1, 1, 1, 1, 3, 2, 1};
            cycle("t2");
            chk("t2.id", 32'(grant_ID), 32'(exp_id[i]));
            chk("t2.credit", 32'(credit_left), 32'(exp_cr[i]));
        end

        // 3: holder drops request, remaining credit discarded
        hard_reset();
        setw(0, 3);
        setw(1, 2);
        req = 4'b0011;
        cycle("t3.a");
        chk("t3.first", 32'(grant), 32'd1);
        req = 4'b0010;
        cycle("t3.b");
        chk("t3.second_id", 32'(grant_ID), 32'd1);
        chk("t3.second_credit", 32'(credit_left), 32'd2);

        // 4: sole requester re-wins with fresh credit
        hard_reset();
        setw(2, 2);
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            cycle("t4");
            chk("t4.grant", 32'(grant), 32'd4);
            chk("t4.credit", 32'(credit_left), 32'((i % 2 == 0) ? 2 : 1));
        end

        // 5: disable in the middle of a burst; resume from the moved pointer
        hard_reset();
        setw(1, 5);
        req = 4'b0010;
        repeat (2) cycle("t5.burst");
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("t5.off");
            chk("t5.off_valid", 32'(grant_valid), 32'd0);
            chk("t5.off_grant", 32'(grant), 32'd0);
        end
        en = 1'b1;
        req = 4'b1111;
        cycle("t5.resume");
        chk("t5.resume_id", 32'(grant_ID), 32'd2);

        // 6: zero weight counts as one
        hard_reset();
        setw(0, 0);
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            cycle("t6");
            chk("t6.credit", 32'(credit_left), 32'd1);
        end
`ifdef WRR_LOCK_EN
        hard_reset();
        setw(1, 2);
        req = 4'b0010;
        lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req = (i == 0) ? 4'b0010 : 4'b1111;
            cycle("t6.lock");
            chk("t6.lock_id", 32'(grant_ID), 32'd1);
            chk("t6.lock_credit", 32'(credit_left), 32'((i == 0) ? 2 : 1));
        end
        lock = 1'b0;
        cycle("t6.unlock");
        chk("t6.unlock_id", 32'(grant_ID), 32'd2);
`endif

        // random traffic against the model
        hard_reset();
        for (int i = 0; i < 400; i++) begin
            req = N'($urandom);
            if ($urandom_range(0, 3) == 0) weight = (N*WW)'($urandom);
            en = ($urandom_range(0, 7) != 0);
`ifdef WRR_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
`endif
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
